fxp_add_arbiter: RTL and testbench

Shares one fixed-point adder datapath between NUM_REQ requesters using round-robin arbitration. Each requester presents an operand pair through a valid/ready handshake. The winning pair is added and the sum is held in a single-entry output register, tagged with the requester ID. The block sits between requester front-ends and downstream consumers of fixed-point sums, and supports output backpressure.

---
 rtl/fxp_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 78 +++++++
 rtl/fxp_add_arbiter.sv | 146 ++++++++++++++
 tb/tb_fxp_add_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// ---------------------------------------------------------------------------
// fxp_pkg
// Shared helpers for the fixed-point adder arbiter: width functions for the
// sum and requester-id buses, plus the output register state enum.
// No ports; imported by rr_arbiter and fxp_add_arbiter.
// ---------------------------------------------------------------------------
package fxp_pkg;

    // Sum width keeps one extra bit so the carry out of the add is never lost.
    function automatic int fxp_sum_w(input int n, input int m);
        return n + m + 1;
    endfunction

    // Index width for a set of requesters; never narrower than one bit.
    function automatic int id_w(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

    // Single-entry output register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } outState_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a rotating priority pointer. Searches requests
// starting at the pointer and grants the first one found. When 'advance' is
// high the pointer moves to one past 'grant_in'.
// Ports:
//   clk, rst   : clock and synchronous active-high reset (pointer -> 0)
//   req        : request vector (already qualified by the caller)
//   advance    : a grant was consumed this cycle
//   grant_in   : index of the consumed grant
//   grant      : one-hot grant (all zero when no request)
//   grant_idx  : binary index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter
    import fxp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IdW    = id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [IdW-1:0]     grant_in,
    output logic [NUM_REQ-1:0] grant,
    output logic [IdW-1:0]     grant_idx
);

    // One extra bit so pointer plus offset never overflows before the wrap.
    localparam logic [IdW:0]   NumReqW = (IdW + 1)'(NUM_REQ);
    localparam logic [IdW-1:0] LastIdx = IdW'(NUM_REQ - 1);

    logic [IdW-1:0] ptr_q;
    logic [IdW-1:0] ptr_d;
    logic [IdW:0]   sumIdx;
    logic [IdW-1:0] scanIdx;
    logic           found;

    // Walk the requests starting at the pointer, wrapping at NUM_REQ, and
    // grant the first one that is set.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sumIdx    = '0;
        scanIdx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sumIdx = {1'b0, ptr_q} + (IdW + 1)'(k);
            if (sumIdx >= NumReqW) begin
                sumIdx = sumIdx - NumReqW;
            end
            scanIdx = sumIdx[IdW-1:0];
            if (!found && req[scanIdx]) begin
                found          = 1'b1;
                grant[scanIdx] = 1'b1;
                grant_idx      = scanIdx;
            end
        end
    end

    // The winner drops to lowest priority once its grant has been used.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_in == LastIdx) ? '0 : grant_in + IdW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fxp_add_arbiter.sv
// ---------------------------------------------------------------------------
// fxp_add_arbiter
// Shares one unsigned fixed-point adder between NUM_REQ requesters. The
// round-robin winner's operand pair is added and stored in a single-entry
// output register tagged with the requester id; output supports backpressure.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   req_valid  : per-requester operand pair valid
//   req_ready  : per-requester accept strobe (one-hot or zero)
//   req_a/b    : packed operands, requester i at [i*(N+M) +: N+M]
//   res_valid  : output register holds a sum
//   res_ready  : downstream accepts the sum
//   res_sum    : N+M+1 bit unsigned sum, carry in the MSB
//   res_id     : requester that produced res_sum
//   op_count   : sums accepted downstream, wrapping
//   busy       : same as res_valid
// ---------------------------------------------------------------------------
module fxp_add_arbiter
    import fxp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int N       = 8,
    parameter int M       = 8,
    parameter int CNT_W   = 16,
    localparam int OpW    = N + M,
    localparam int SumW   = fxp_sum_w(N, M),
    localparam int IdW    = id_w(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*OpW-1:0] req_a,
    input  logic [NUM_REQ*OpW-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SumW-1:0]        res_sum,
    output logic [IdW-1:0]         res_id,
    output logic [CNT_W-1:0]       op_count,
    output logic                   busy
);

    outState_e          state_q;
    outState_e          state_d;
    logic [SumW-1:0]    resSum_q;
    logic [SumW-1:0]    resSum_d;
    logic [IdW-1:0]     resId_q;
    logic [IdW-1:0]     resId_d;
    logic [CNT_W-1:0]   opCount_q;
    logic [CNT_W-1:0]   opCount_d;

    logic               canAccept;
    logic [NUM_REQ-1:0] arbReq;
    logic [NUM_REQ-1:0] grant;
    logic [IdW-1:0]     grantIdx;
    logic               transfer;
    logic [OpW-1:0]     opA;
    logic [OpW-1:0]     opB;
    logic [SumW-1:0]    sumNew;

    // Requests are only offered to the arbiter when the output slot is free
    // or being emptied this cycle, and never while reset is held, so the
    // ready strobes depend only on valid, res_ready and state.
    always_comb begin
        canAccept = (state_q == EMPTY) || res_ready;
        arbReq    = (canAccept && !rst) ? req_valid : '0;
        req_ready = grant;
        transfer  = |grant;
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (arbReq),
        .advance   (transfer),
        .grant_in  (grantIdx),
        .grant     (grant),
        .grant_idx (grantIdx)
    );

    // One-hot operand mux feeding the shared adder; zero-extend both
    // operands so the carry appears in the MSB.
    always_comb begin
        opA = '0;
        opB = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                opA = req_a[i*OpW +: OpW];
                opB = req_b[i*OpW +: OpW];
            end
        end
        sumNew = SumW'(opA) + SumW'(opB);
    end

    // Output register occupancy: a new transfer always fills it, otherwise
    // a downstream accept empties it.
    always_comb begin
        state_d = state_q;
        if (transfer) begin
            state_d = FULL;
        end else if ((state_q == FULL) && res_ready) begin
            state_d = EMPTY;
        end
    end

    // Payload and counter next values. Sum and id hold after a drain.
    always_comb begin
        resSum_d  = resSum_q;
        resId_d   = resId_q;
        opCount_d = opCount_q;
        if (transfer) begin
            resSum_d = sumNew;
            resId_d  = grantIdx;
        end
        if ((state_q == FULL) && res_ready) begin
            opCount_d = opCount_q + CNT_W'(1);
        end
    end

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            resSum_q  <= '0;
            resId_q   <= '0;
            opCount_q <= '0;
        end else begin
            state_q   <= state_d;
            resSum_q  <= resSum_d;
            resId_q   <= resId_d;
            opCount_q <= opCount_d;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        res_valid = (state_q == FULL);
        busy      = (state_q == FULL);
        res_sum   = resSum_q;
        res_id    = resId_q;
        op_count  = opCount_q;
    end

endmodule

// File: tb/tb_fxp_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fxp_add_arbiter
// Directed bench for fxp_add_arbiter with NUM_REQ=4, N=M=8, CNT_W=16.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fxp_add_arbiter;

    localparam int NumReq = 4;
    localparam int OpW    = 16;

    logic              clk;
    logic              rst;
    logic [3:0]        reqValid;
    logic [3:0]        reqReady;
    logic [63:0]       reqA;
    logic [63:0]       reqB;
    logic              resValid;
    logic              resReady;
    logic [16:0]       resSum;
    logic [1:0]        resId;
    logic [15:0]       opCount;
    logic              busy;

    int assertCount;
    int failCount;

    fxp_add_arbiter #(
        .NUM_REQ (NumReq),
        .N       (8),
        .M       (8),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_a     (reqA),
        .req_b     (reqB),
        .res_valid (resValid),
        .res_ready (resReady),
        .res_sum   (resSum),
        .res_id    (resId),
        .op_count  (opCount),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive request valids and downstream ready.
    task automatic applyStimulus(input logic [3:0] valid, input logic ready);
        reqValid = valid;
        resReady = ready;
        #1;
    endtask

    // Load one requester's operand pair.
    task automatic setOperands(input int idx, input logic [15:0] a, input logic [15:0] b);
        reqA[idx*OpW +: OpW] = a;
        reqB[idx*OpW +: OpW] = b;
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst         = 1'b1;
        reqValid    = 4'hF;
        resReady    = 1'b1;
        reqA        = '0;
        reqB        = '0;

        // Reset held two cycles with every requester asking.
        tick();
        tick();
        checkOutput("rst_res_valid", 32'(resValid), 32'd0);
        checkOutput("rst_op_count", 32'(opCount), 32'd0);
        checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
        checkOutput("rst_res_sum", 32'(resSum), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("first_grant", 32'(reqReady), 32'h1);

        // Idle: nothing valid means nothing ready and nothing stored.
        applyStimulus(4'b0000, 1'b1);
        checkOutput("idle_req_ready", 32'(reqReady), 32'd0);
        tick();
        checkOutput("idle_res_valid", 32'(resValid), 32'd0);

        // Single add from requester 2: 1.5 + 2.25 = 3.75.
        setOperands(2, 16'h0180, 16'h0240);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("add_req_ready", 32'(reqReady), 32'h4);
        tick();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("add_res_valid", 32'(resValid), 32'd1);
        checkOutput("add_res_sum", 32'(resSum), 32'h003C0);
        checkOutput("add_res_id", 32'(resId), 32'd2);
        checkOutput("add_op_count_pre", 32'(opCount), 32'd0);
        tick();
        checkOutput("add_drained", 32'(resValid), 32'd0);
        checkOutput("add_op_count", 32'(opCount), 32'd1);
        checkOutput("add_sum_hold", 32'(resSum), 32'h003C0);

        // Carry out lands in the MSB.
        setOperands(3, 16'hFF00, 16'h0100);
        applyStimulus(4'b1000, 1'b1);
        tick();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("carry_res_sum", 32'(resSum), 32'h10000);
        checkOutput("carry_res_id", 32'(resId), 32'd3);
        tick();
        checkOutput("carry_op_count", 32'(opCount), 32'd2);

        // Round robin with all four valid; pointer is back at 0.
        for (int i = 0; i < NumReq; i++) begin
            setOperands(i, 16'((i + 1) * 16'h0100), 16'h0001);
        end
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("rr_ready_%0d", k), 32'(reqReady), 32'(1 << (k % 4)));
            tick();
            checkOutput($sformatf("rr_id_%0d", k), 32'(resId), 32'(k % 4));
            checkOutput($sformatf("rr_sum_%0d", k), 32'(resSum), 32'(((k % 4) + 1) * 256 + 1));
        end
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("rr_op_count", 32'(opCount), 32'd10);
        checkOutput("rr_drained", 32'(resValid), 32'd0);

        // Backpressure: fill from requester 1, then stall with it pending.
        setOperands(1, 16'h0A00, 16'h0050);
        applyStimulus(4'b0010, 1'b0);
        tick();
        setOperands(1, 16'h0300, 16'h0004);
        for (int s = 0; s < 5; s++) begin
            checkOutput($sformatf("bp_ready_%0d", s), 32'(reqReady), 32'd0);
            checkOutput($sformatf("bp_sum_%0d", s), 32'(resSum), 32'h00A50);
            checkOutput($sformatf("bp_id_%0d", s), 32'(resId), 32'd1);
            checkOutput($sformatf("bp_valid_%0d", s), 32'(resValid), 32'd1);
            tick();
        end
        checkOutput("bp_op_count", 32'(opCount), 32'd10);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("bp_release_ready", 32'(reqReady), 32'h2);
        tick();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("bp_swap_valid", 32'(resValid), 32'd1);
        checkOutput("bp_swap_sum", 32'(resSum), 32'h00304);
        checkOutput("bp_swap_id", 32'(resId), 32'd1);
        checkOutput("bp_swap_count", 32'(opCount), 32'd11);
        tick();
        checkOutput("bp_final_count", 32'(opCount), 32'd12);

        // Mid-operation reset with a held result and a pending requester.
        setOperands(0, 16'h0111, 16'h0222);
        applyStimulus(4'b0001, 1'b0);
        tick();
        checkOutput("mr_full", 32'(resValid), 32'd1);
        checkOutput("mr_sum", 32'(resSum), 32'h00333);
        applyStimulus(4'b1000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b1);
        checkOutput("mr_res_valid", 32'(resValid), 32'd0);
        checkOutput("mr_op_count", 32'(opCount), 32'd0);
        checkOutput("mr_res_sum", 32'(resSum), 32'd0);
        checkOutput("mr_res_id", 32'(resId), 32'd0);
        tick();
        checkOutput("mr_no_stale", 32'(resValid), 32'd0);
        // Pointer must be back at 0: requester 0 beats requester 3.
        applyStimulus(4'b1001, 1'b1);
        checkOutput("mr_ptr_grant", 32'(reqReady), 32'h1);
        tick();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("mr_post_id", 32'(resId), 32'd0);
        checkOutput("mr_post_sum", 32'(resSum), 32'h00333);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
